// File: rtl/cc_ack_collector_pkg.sv
// Shared coherence types for the ack collector: MSHR index/thread types,
// per-entry state encoding and the LSB-first priority encoder.
package cc_ack_collector_pkg;

  localparam int unsigned MSHR_SIZE  = 8;
  localparam int unsigned MSHR_IDX_W = $clog2(MSHR_SIZE);
  localparam int unsigned THREAD_W   = 2;

  typedef logic [MSHR_IDX_W-1:0] mshr_idx_t;
  typedef logic [THREAD_W-1:0]   thread_id_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    COMPLETE = 2'd2,
    OUT      = 2'd3
  } cc_ack_state_t;

  typedef struct packed {
    mshr_idx_t  index;
    thread_id_t thread;
  } done_payload_t;

  // Lowest set bit wins; returns 0 when no bit is set.
  function automatic mshr_idx_t priority_encoder_npu(input logic [MSHR_SIZE-1:0] req);
    mshr_idx_t idx;
    idx = '0;
    for (int i = MSHR_SIZE - 1; i >= 0; i--) begin
      if (req[i]) idx = mshr_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cc_ack_collector_entry.sv
// One MSHR tracking slot: lifecycle FSM, signed inv-ack counter, data flag
// and latched thread id. o_err_c pulses when an event to this slot is dropped.
module cc_ack_entry
  import cc_ack_collector_pkg::*;
#(
  parameter int unsigned ACK_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_alloc,
  input  thread_id_t           i_thread,
  input  logic                 i_data,
  input  logic [ACK_WIDTH-1:0] i_data_count,
  input  logic                 i_ack,
  input  logic                 i_cancel,
  input  logic                 i_select,
  input  logic                 i_release,
  output cc_ack_state_t        o_state,
  output thread_id_t           o_thread,
  output logic                 o_err_c
);

  // Two guard bits cover cnt + max count and cnt - 1 without wrapping.
  localparam int unsigned SW = ACK_WIDTH + 2;

  cc_ack_state_t               r_state;
  logic signed [ACK_WIDTH-1:0] r_cnt;
  logic                        r_rcvd;
  thread_id_t                  r_thread;

  logic                        w_data_eff;
  logic                        w_ack_eff;
  logic                        w_err;
  logic                        w_fit;
  logic signed [SW-1:0]        w_inc;
  logic signed [SW-1:0]        w_dec;
  logic signed [SW-1:0]        w_sum;
  logic signed [ACK_WIDTH-1:0] w_cnt_nxt;
  logic                        w_rcvd_nxt;

  // Event qualification, range check and next counter/flag values.
  always_comb begin
    w_data_eff = 1'b0;
    w_ack_eff  = 1'b0;
    w_err      = 1'b0;
    w_cnt_nxt  = r_cnt;
    w_rcvd_nxt = r_rcvd;
    case (r_state)
      IDLE: w_err = i_data || i_ack;
      WAIT: begin
        if (!i_cancel) begin
          w_data_eff = i_data && !r_rcvd;
          w_ack_eff  = i_ack;
          w_err      = i_data && r_rcvd;
        end
      end
      default: w_err = i_data;
    endcase
    if (i_alloc && (r_state != IDLE)) w_err = 1'b1;

    w_inc = w_data_eff ? SW'(i_data_count) : '0;
    w_dec = w_ack_eff ? SW'(1) : '0;
    w_sum = SW'(r_cnt) + w_inc - w_dec;
    w_fit = (&w_sum[SW-1:ACK_WIDTH-1]) || (~|w_sum[SW-1:ACK_WIDTH-1]);

    if (w_data_eff || w_ack_eff) begin
      if (w_fit) begin
        w_cnt_nxt  = w_sum[ACK_WIDTH-1:0];
        w_rcvd_nxt = r_rcvd | w_data_eff;
      end else begin
        w_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rcvd   <= 1'b0;
      r_thread <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_alloc) begin
            r_state  <= WAIT;
            r_cnt    <= '0;
            r_rcvd   <= 1'b0;
            r_thread <= i_thread;
          end
        end
        WAIT: begin
          if (i_cancel) begin
            r_state <= IDLE;
          end else begin
            r_cnt  <= w_cnt_nxt;
            r_rcvd <= w_rcvd_nxt;
            if (w_rcvd_nxt && (w_cnt_nxt == '0)) r_state <= COMPLETE;
          end
        end
        COMPLETE: begin
          if (i_cancel)      r_state <= IDLE;
          else if (i_select) r_state <= OUT;
        end
        OUT: begin
          if (i_release) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_thread = r_thread;
  assign o_err_c  = w_err;

endmodule

// File: rtl/cc_ack_collector.sv
// Completion tracker for outstanding MSHR transactions: one cc_ack_entry per
// MSHR, LSB-first selection into a single registered valid/ready output.
module cc_ack_collector
  import cc_ack_collector_pkg::*;
#(
  parameter int unsigned ACK_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_valid,
  input  mshr_idx_t            alloc_index,
  input  thread_id_t           alloc_thread,
  input  logic                 data_valid,
  input  mshr_idx_t            data_index,
  input  logic [ACK_WIDTH-1:0] data_ack_count,
  input  logic                 ack_valid,
  input  mshr_idx_t            ack_index,
  input  logic                 cancel_valid,
  input  mshr_idx_t            cancel_index,
  output logic                 done_valid,
  input  logic                 done_ready,
  output mshr_idx_t            done_index,
  output thread_id_t           done_thread,
  output logic [MSHR_SIZE-1:0] pending,
  output logic                 error
);

  logic                 r_done_valid;
  mshr_idx_t            r_done_index;
  thread_id_t           r_done_thread;
  logic                 r_error;

  logic [MSHR_SIZE-1:0] w_alloc;
  logic [MSHR_SIZE-1:0] w_data;
  logic [MSHR_SIZE-1:0] w_ack;
  logic [MSHR_SIZE-1:0] w_cancel;
  logic [MSHR_SIZE-1:0] w_select;
  logic [MSHR_SIZE-1:0] w_release;
  logic [MSHR_SIZE-1:0] w_complete;
  logic [MSHR_SIZE-1:0] w_cand;
  logic [MSHR_SIZE-1:0] w_err;
  cc_ack_state_t        w_state  [MSHR_SIZE];
  thread_id_t           w_thread [MSHR_SIZE];
  logic                 w_load_en;
  logic                 w_any;
  mshr_idx_t            w_sel_idx;

  for (genvar g = 0; g < MSHR_SIZE; g++) begin : g_entry
    assign w_alloc[g]   = alloc_valid  && (alloc_index  == mshr_idx_t'(g));
    assign w_data[g]    = data_valid   && (data_index   == mshr_idx_t'(g));
    assign w_ack[g]     = ack_valid    && (ack_index    == mshr_idx_t'(g));
    assign w_cancel[g]  = cancel_valid && (cancel_index == mshr_idx_t'(g));
    assign w_select[g]  = w_load_en && w_any && (w_sel_idx == mshr_idx_t'(g));
    assign w_release[g] = r_done_valid && done_ready && (r_done_index == mshr_idx_t'(g));

    cc_ack_entry #(.ACK_WIDTH(ACK_WIDTH)) u_entry (
      .clk          (clk),
      .reset        (reset),
      .i_alloc      (w_alloc[g]),
      .i_thread     (alloc_thread),
      .i_data       (w_data[g]),
      .i_data_count (data_ack_count),
      .i_ack        (w_ack[g]),
      .i_cancel     (w_cancel[g]),
      .i_select     (w_select[g]),
      .i_release    (w_release[g]),
      .o_state      (w_state[g]),
      .o_thread     (w_thread[g]),
      .o_err_c      (w_err[g])
    );

    assign w_complete[g] = (w_state[g] == COMPLETE);
    assign pending[g]    = (w_state[g] != IDLE);
  end

  // A same-cycle cancel removes the entry from selection; the next one is picked.
  assign w_cand    = w_complete & ~w_cancel;
  assign w_any     = |w_cand;
  assign w_sel_idx = priority_encoder_npu(w_cand);
  assign w_load_en = !r_done_valid || done_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_done_valid  <= 1'b0;
      r_done_index  <= '0;
      r_done_thread <= '0;
      r_error       <= 1'b0;
    end else begin
      r_error <= r_error | (|w_err);
      if (w_load_en) begin
        r_done_valid <= w_any;
        if (w_any) begin
          r_done_index  <= w_sel_idx;
          r_done_thread <= w_thread[w_sel_idx];
        end
      end
    end
  end

  assign done_valid  = r_done_valid;
  assign done_index  = r_done_index;
  assign done_thread = r_done_thread;
  assign error       = r_error;

endmodule

// File: tb/tb_cc_ack_collector.sv
// Directed bench for cc_ack_collector: expected completions go into a queue,
// a negedge monitor pops them on each handshake and checks output stability.
module tb_cc_ack_collector;
  import cc_ack_collector_pkg::*;

  localparam int unsigned ACK_WIDTH = 5;

  logic                 clk;
  logic                 reset;
  logic                 alloc_valid;
  mshr_idx_t            alloc_index;
  thread_id_t           alloc_thread;
  logic                 data_valid;
  mshr_idx_t            data_index;
  logic [ACK_WIDTH-1:0] data_ack_count;
  logic                 ack_valid;
  mshr_idx_t            ack_index;
  logic                 cancel_valid;
  mshr_idx_t            cancel_index;
  logic                 done_valid;
  logic                 done_ready;
  mshr_idx_t            done_index;
  thread_id_t           done_thread;
  logic [MSHR_SIZE-1:0] pending;
  logic                 error;

  int total = 0;
  int bad   = 0;
  done_payload_t exp_q[$];

  cc_ack_collector #(.ACK_WIDTH(ACK_WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_index    (alloc_index),
    .alloc_thread   (alloc_thread),
    .data_valid     (data_valid),
    .data_index     (data_index),
    .data_ack_count (data_ack_count),
    .ack_valid      (ack_valid),
    .ack_index      (ack_index),
    .cancel_valid   (cancel_valid),
    .cancel_index   (cancel_index),
    .done_valid     (done_valid),
    .done_ready     (done_ready),
    .done_index     (done_index),
    .done_thread    (done_thread),
    .pending        (pending),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop on every handshake, check hold stability while stalled.
  logic       held = 1'b0;
  mshr_idx_t  held_idx;
  thread_id_t held_thr;
  always @(negedge clk) begin
    done_payload_t e;
    if (!reset || !done_valid) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_index", 32'(done_index), 32'(held_idx));
        check("hold_thread", 32'(done_thread), 32'(held_thr));
      end
      if (done_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got index %0d with empty queue", done_index);
        end else begin
          e = exp_q.pop_front();
          if (done_index !== e.index || done_thread !== e.thread) begin
            bad++;
            $display("FAIL done_payload: got idx %0d thr %0d expected idx %0d thr %0d",
                     done_index, done_thread, e.index, e.thread);
          end
        end
        held = 1'b0;
      end else begin
        held     = 1'b1;
        held_idx = done_index;
        held_thr = done_thread;
      end
    end
  end

  task automatic clear_inputs();
    alloc_valid  = 1'b0;
    data_valid   = 1'b0;
    ack_valid    = 1'b0;
    cancel_valid = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic drv_alloc(input mshr_idx_t i, input thread_id_t t);
    alloc_valid = 1'b1; alloc_index = i; alloc_thread = t;
  endtask

  task automatic drv_data(input mshr_idx_t i, input logic [ACK_WIDTH-1:0] c);
    data_valid = 1'b1; data_index = i; data_ack_count = c;
  endtask

  task automatic drv_ack(input mshr_idx_t i);
    ack_valid = 1'b1; ack_index = i;
  endtask

  task automatic push_exp(input mshr_idx_t i, input thread_id_t t);
    done_payload_t e;
    e.index  = i;
    e.thread = t;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done_valid"},  32'(done_valid),  32'd0);
    check({tag, "_done_index"},  32'(done_index),  32'd0);
    check({tag, "_done_thread"}, 32'(done_thread), 32'd0);
    check({tag, "_pending"},     32'(pending),     32'd0);
    check({tag, "_error"},       32'(error),       32'd0);
  endtask

  initial begin
    reset = 1'b0; done_ready = 1'b1;
    alloc_index = '0; alloc_thread = '0; data_index = '0; data_ack_count = '0;
    ack_index = '0; cancel_index = '0;
    clear_inputs();
    cycle(); cycle();
    check_reset_outputs("rst0");
    reset = 1'b1;
    cycle();

    // Simple completion with zero acks on idx 2.
    drv_alloc(3'd2, 2'd1); cycle();
    check("t1_pending_set", 32'(pending), 32'h04);
    drv_data(3'd2, 5'd0); push_exp(3'd2, 2'd1); cycle();
    check("t1_not_yet_valid", 32'(done_valid), 32'd0);
    cycle();
    check("t1_valid", 32'(done_valid), 32'd1);
    check("t1_index", 32'(done_index), 32'd2);
    cycle();
    check("t1_pending_clr", 32'(pending), 32'h00);
    check("t1_valid_clr", 32'(done_valid), 32'd0);

    // Acks before data drive the counter negative.
    drv_alloc(3'd1, 2'd2); cycle();
    drv_ack(3'd1); cycle();
    drv_ack(3'd1); cycle();
    check("t2_no_early_done", 32'(done_valid), 32'd0);
    check("t2_pending", 32'(pending), 32'h02);
    drv_data(3'd1, 5'd2); push_exp(3'd1, 2'd2); cycle();
    cycle();
    check("t2_valid", 32'(done_valid), 32'd1);
    check("t2_index", 32'(done_index), 32'd1);
    cycle();

    // Last ack to idx 3 coincides with data to idx 6.
    drv_alloc(3'd3, 2'd3); cycle();
    drv_alloc(3'd6, 2'd0); cycle();
    drv_data(3'd3, 5'd3); cycle();
    drv_ack(3'd3); cycle();
    drv_ack(3'd3); cycle();
    drv_ack(3'd3); drv_data(3'd6, 5'd1); push_exp(3'd3, 2'd3); cycle();
    cycle();
    check("t3_valid", 32'(done_valid), 32'd1);
    check("t3_index", 32'(done_index), 32'd3);
    cycle();
    check("t3_idx6_waiting", 32'(pending), 32'h40);
    check("t3_no_done", 32'(done_valid), 32'd0);
    drv_ack(3'd6); push_exp(3'd6, 2'd0); cycle();
    cycle();
    check("t3_idx6_index", 32'(done_index), 32'd6);
    cycle();
    check("t3_all_idle", 32'(pending), 32'h00);

    // idx 0 and idx 4 complete together while the controller stalls.
    drv_alloc(3'd0, 2'd1); cycle();
    drv_alloc(3'd4, 2'd2); cycle();
    done_ready = 1'b0;
    drv_data(3'd0, 5'd1); cycle();
    drv_data(3'd4, 5'd0); drv_ack(3'd0); push_exp(3'd0, 2'd1); push_exp(3'd4, 2'd2); cycle();
    cycle();
    check("t4_first_index", 32'(done_index), 32'd0);
    cycle();
    cycle();
    check("t4_still_index0", 32'(done_index), 32'd0);
    check("t4_still_valid", 32'(done_valid), 32'd1);
    done_ready = 1'b1;
    cycle();
    check("t4_b2b_valid", 32'(done_valid), 32'd1);
    check("t4_b2b_index", 32'(done_index), 32'd4);
    cycle();
    check("t4_drained", 32'(done_valid), 32'd0);

    // Cancel idx 5 at cnt=-1, then a clean re-allocation.
    drv_alloc(3'd5, 2'd3); cycle();
    drv_ack(3'd5); cycle();
    cancel_valid = 1'b1; cancel_index = 3'd5; cycle();
    check("t5_cancel_idle", 32'(pending), 32'h00);
    drv_alloc(3'd5, 2'd1); cycle();
    drv_data(3'd5, 5'd0); push_exp(3'd5, 2'd1); cycle();
    cycle();
    check("t5_index", 32'(done_index), 32'd5);
    check("t5_thread", 32'(done_thread), 32'd1);
    check("t5_no_error", 32'(error), 32'd0);
    cycle();

    // Ack to an IDLE entry is an error that sticks until reset.
    drv_ack(3'd7); cycle();
    check("t6_idle_ack_err", 32'(error), 32'd1);
    cycle(); cycle();
    check("t6_err_sticky", 32'(error), 32'd1);
    reset = 1'b0; cycle(); reset = 1'b1;
    check_reset_outputs("rst1");

    // Counter boundary: -16 is legal, a 17th early ack is dropped.
    drv_alloc(3'd2, 2'd0); cycle();
    for (int n = 0; n < 16; n++) begin
      drv_ack(3'd2); cycle();
    end
    check("t7_min_legal", 32'(error), 32'd0);
    drv_ack(3'd2); cycle();
    check("t7_underflow_err", 32'(error), 32'd1);
    drv_data(3'd2, 5'd16); push_exp(3'd2, 2'd0); cycle();
    cycle();
    check("t7_valid", 32'(done_valid), 32'd1);
    check("t7_index", 32'(done_index), 32'd2);
    cycle();
    reset = 1'b0; cycle(); reset = 1'b1;
    check_reset_outputs("rst2");

    // Second data response is dropped and flagged.
    drv_alloc(3'd7, 2'd2); cycle();
    drv_data(3'd7, 5'd1); cycle();
    check("t8_no_err_yet", 32'(error), 32'd0);
    drv_data(3'd7, 5'd0); cycle();
    check("t8_double_data_err", 32'(error), 32'd1);
    cycle();
    check("t8_still_waiting", 32'(pending), 32'h80);
    check("t8_no_done", 32'(done_valid), 32'd0);
    reset = 1'b0; cycle(); reset = 1'b1;
    check_reset_outputs("rst3");

    cycle(); cycle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_ack_collector.md
# cc_ack_collector

Response-side completion tracker for the L1 cache controller. It follows each MSHR index from the moment the controller allocates a coherence transaction: it records the data response and its expected invalidation-ack count, and counts the inv-acks that arrive from peer caches. When a transaction is complete it hands the MSHR index and the requesting thread back to the cache controller over a valid/ready port, so the controller can deallocate the MSHR entry and wake the thread. It sits between the network-interface response demux and cache controller stage 1.

## Interface
Parameters:
- ACK_WIDTH, default 5: width of the signed two's-complement ack counter; legal count range is -(2^(ACK_WIDTH-1)) to 2^(ACK_WIDTH-1)-1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- alloc_valid  in  1  start tracking a transaction.
- alloc_index  in  mshr_idx_t  MSHR index being allocated.
- alloc_thread  in  thread_id_t  requesting HW thread.
- data_valid  in  1  data/grant response arrived.
- data_index  in  mshr_idx_t  target entry of the data response.
- data_ack_count  in  ACK_WIDTH  unsigned count of inv-acks still expected.
- ack_valid  in  1  one invalidation ack arrived.
- ack_index  in  mshr_idx_t  target entry of the ack.
- cancel_valid  in  1  abort tracking (controller flush path).
- cancel_index  in  mshr_idx_t  entry to abort.
- done_valid  out  1  completion available.
- done_ready  in  1  controller accepts the completion.
- done_index  out  mshr_idx_t  completed MSHR index.
- done_thread  out  thread_id_t  thread to wake.
- pending  out  `MSHR_SIZE  one bit per entry; set when the entry is not IDLE.
- error  out  1  sticky protocol-error flag.

## Operation
- Each of the `MSHR_SIZE entries has a state, a data_received flag, a signed ack counter cnt and a thread id.
- Entry FSM has four states: IDLE, WAIT, COMPLETE and OUT.
  - IDLE→WAIT on alloc. On entry: cnt=0, data_received=0, thread latched.
  - WAIT→COMPLETE on the edge where the next-state value satisfies data_received && cnt==0.
  - COMPLETE→OUT when the entry is selected into the output register.
  - OUT→IDLE on done_valid && done_ready.
- Counter update in WAIT. The next value is cnt + (data_valid hit ? data_ack_count : 0) − (ack_valid hit ? 1 : 0).
  - A data response and an ack to the same entry in the same cycle are both applied.
  - Acks arriving before the data response drive cnt negative; this is legal.
- Output selection:
  - The output register is loaded when it is empty, or on the handshake cycle, from the lowest-index entry in COMPLETE (LSB priority).
  - Entries that complete in the same cycle drain one per cycle.
- Cancel:
  - Cancel moves a WAIT or COMPLETE entry to IDLE.
  - Cancel of an OUT entry is ignored; the completion is still delivered.
  - Cancel of an IDLE entry is a no-op.
- Cancel of a COMPLETE entry in the same cycle it is being selected:
  - Cancel takes priority and the entry is not loaded.
  - Selection picks the next COMPLETE entry.
- error is set sticky (cleared only by reset) on any of the following. The offending event is dropped.
  - alloc to a non-IDLE entry.
  - data or ack to an IDLE entry.
  - A second data response to the same entry.
  - A counter update that would leave the legal signed range.
- Alloc and cancel to the same index in the same cycle: alloc wins if the entry is IDLE; otherwise cancel applies and error is set.

## Timing
- Reset values: done_valid=0, done_index=0, done_thread=0, pending=0, error=0; all entries IDLE, all counters 0.
- alloc sampled at edge k → pending[i]=1 after edge k.
- The final event (data or last ack) is sampled at edge k → entry is COMPLETE after edge k → done_valid=1 after edge k+1, provided the output register is free.
- done_valid, once high, holds with stable index and thread until done_ready.
- After a handshake at edge m:
  - pending[i] clears after edge m.
  - A different COMPLETE entry may present after the same edge m, giving back-to-back throughput of one per cycle.
- The freed index may be re-allocated from the cycle after edge m.

## Structure
- These belong in the shared coherence defines/package: mshr_idx_t, thread_id_t, `MSHR_SIZE, and a cc_ack_state_t enum (IDLE, WAIT, COMPLETE, OUT).
- One sub-module: cc_ack_entry, holding the per-entry FSM, counter and flag logic. It is instantiated `MSHR_SIZE times in a generate loop.
- The top level holds the LSB priority selection (reusing priority_encoder_npu), the output register and the error OR-reduction.

## Test plan
- alloc idx 2, then data with ack_count=0 → done_valid two cycles after data, done_index=2; pending[2] clears after handshake.
- alloc idx 1; two acks; then data with ack_count=2 → cnt goes 0→−1→−2→0; completion after data.
- alloc idx 3; data with ack_count=3; the third ack arrives in the same cycle as an unrelated data response → idx 3 completes; counters do not interfere.
- idx 0 and idx 4 complete in the same cycle with done_ready held low for 3 cycles → index 0 held stable, then index 4 on the cycle after its handshake.
- Cancel idx 5 while it is in WAIT with cnt=−1, then re-alloc idx 5 and send data with ack_count=0 → clean completion, error=0.
- Ack to an IDLE entry, and a double data response → error=1 and stays set; reset low for one edge → all outputs back to 0.
